seg_scan_driver: RTL and testbench

- Parametrised multi-digit seven-segment display driver and the successor to the single-digit BCD decoder.
- Decodes a packed vector of 4-bit nibbles and time-multiplexes the digits onto one shared segment bus plus one-hot anode selects.
- Adds full hex glyphs, leading-zero blanking, decimal points, a global blank, polarity selection and tear-free frame-synchronous updates.
- Sits between the counter datapath and the board display pins.

---
 rtl/seg_scan_driver.sv | 234 +++++++++++++++++++++++
 tb/tb_seg_scan_driver.sv | 222 ++++++++++++++++++++++
 2 files changed

// File: rtl/seg_scan_driver.sv
// -----------------------------------------------------------------------------
// seg_scan_driver
//
// Multi-digit seven-segment display driver. A packed vector of 4-bit nibbles
// is captured into a shadow register on a load strobe. The shadow is copied
// into the display registers only at a frame wrap, so a frame never shows a
// mix of old and new digits. The digits are time-multiplexed onto one shared
// segment bus with one-hot anode selects. Hex glyphs, leading-zero blanking,
// per-digit decimal points, a global blank and output polarity are supported.
//
// Parameters
//   NUM_DIGITS    number of multiplexed digits (1..8)
//   SCAN_DIV      clock cycles each digit stays lit (>= 2)
//   HEX_MODE      1: nibbles 10..15 show A b C d E F; 0: they show blank
//   BLANK_LEADING 1: suppress leading zeros (digit 0 is never suppressed)
//   ACTIVE_LOW    1: seg/dp/anode outputs are active-low; 0: active-high
//
// Ports
//   clk         in   system clock
//   rst_n       in   asynchronous active-low reset
//   digits_in   in   packed nibbles, [3:0] is digit 0 (least significant)
//   dp_in       in   decimal-point request per digit
//   load        in   one-cycle strobe; captures digits_in/dp_in into shadow
//   blank_all   in   level; forces every output to its inactive level
//   seg_out     out  segments {g,f,e,d,c,b,a}
//   dp_out      out  decimal-point segment
//   an_out      out  one-hot digit enable
//   frame_done  out  one-cycle pulse on each frame wrap
// -----------------------------------------------------------------------------
module seg_scan_driver #(
  parameter int NUM_DIGITS    = 4,
  parameter int SCAN_DIV      = 50000,
  parameter int HEX_MODE      = 1,
  parameter int BLANK_LEADING = 1,
  parameter int ACTIVE_LOW    = 1
) (
  input  logic                    clk,
  input  logic                    rst_n,
  input  logic [4*NUM_DIGITS-1:0] digits_in,
  input  logic [NUM_DIGITS-1:0]   dp_in,
  input  logic                    load,
  input  logic                    blank_all,
  output logic [6:0]              seg_out,
  output logic                    dp_out,
  output logic [NUM_DIGITS-1:0]   an_out,
  output logic                    frame_done
);

  localparam int CNT_W = $clog2(SCAN_DIV);
  localparam int IDX_W = (NUM_DIGITS > 1) ? $clog2(NUM_DIGITS) : 1;

  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(SCAN_DIV - 1);
  localparam logic [IDX_W-1:0] IDX_LAST = IDX_W'(NUM_DIGITS - 1);

  // Output polarity: XOR-ing the active-high form with these masks gives
  // the pin levels, and the masks themselves are the inactive pin levels.
  localparam logic                  POL     = (ACTIVE_LOW != 0);
  localparam logic [6:0]            SEG_OFF = {7{POL}};
  localparam logic [NUM_DIGITS-1:0] AN_OFF  = {NUM_DIGITS{POL}};

  localparam logic HEX_ON = (HEX_MODE != 0);
  localparam logic LZ_ON  = (BLANK_LEADING != 0);

  // Active-high glyph table, bit order {g,f,e,d,c,b,a}
  function automatic logic [6:0] decode_glyph(input logic [3:0] nib);
    logic [6:0] g;
    case (nib)
      4'h0:    g = 7'h3F;
      4'h1:    g = 7'h06;
      4'h2:    g = 7'h5B;
      4'h3:    g = 7'h4F;
      4'h4:    g = 7'h66;
      4'h5:    g = 7'h6D;
      4'h6:    g = 7'h7D;
      4'h7:    g = 7'h07;
      4'h8:    g = 7'h7F;
      4'h9:    g = 7'h6F;
      4'hA:    g = HEX_ON ? 7'h77 : 7'h00;
      4'hB:    g = HEX_ON ? 7'h7C : 7'h00;
      4'hC:    g = HEX_ON ? 7'h39 : 7'h00;
      4'hD:    g = HEX_ON ? 7'h5E : 7'h00;
      4'hE:    g = HEX_ON ? 7'h79 : 7'h00;
      4'hF:    g = HEX_ON ? 7'h71 : 7'h00;
      default: g = 7'h00;
    endcase
    return g;
  endfunction

  // Scan state
  logic [CNT_W-1:0]        cnt_q,  cnt_d;
  logic [IDX_W-1:0]        idx_q,  idx_d;
  logic                    wrap_s;

  // Shadow / display state
  logic [4*NUM_DIGITS-1:0] shadow_dig_q, shadow_dig_d;
  logic [NUM_DIGITS-1:0]   shadow_dp_q,  shadow_dp_d;
  logic                    pending_q,    pending_d;
  logic [4*NUM_DIGITS-1:0] disp_dig_q,   disp_dig_d;
  logic [NUM_DIGITS-1:0]   disp_dp_q,    disp_dp_d;

  // Decode path
  logic [NUM_DIGITS-1:0]   lz_blank_s;
  logic                    zero_run_s;
  logic [3:0]              cur_nib_s;
  logic                    cur_dp_s;
  logic                    cur_lz_s;

  // Registered outputs
  logic [6:0]              seg_q,  seg_d;
  logic                    dp_q,   dp_d;
  logic [NUM_DIGITS-1:0]   an_q,   an_d;
  logic                    frame_done_q, frame_done_d;

  // Scan counter and digit index; wrap_s marks the last cycle of a frame
  always_comb begin
    cnt_d        = cnt_q;
    idx_d        = idx_q;
    wrap_s       = 1'b0;
    frame_done_d = 1'b0;
    if (cnt_q == CNT_LAST) begin
      cnt_d = {CNT_W{1'b0}};
      if (idx_q == IDX_LAST) begin
        idx_d        = {IDX_W{1'b0}};
        wrap_s       = 1'b1;
        frame_done_d = 1'b1;
      end else begin
        idx_d = idx_q + IDX_W'(1);
      end
    end else begin
      cnt_d = cnt_q + CNT_W'(1);
    end
  end

  // Shadow capture and frame-synchronous display update. The display copies
  // the pre-edge shadow, so a load landing on the wrap edge stays pending and
  // is shown one frame later.
  always_comb begin
    shadow_dig_d = shadow_dig_q;
    shadow_dp_d  = shadow_dp_q;
    pending_d    = pending_q;
    disp_dig_d   = disp_dig_q;
    disp_dp_d    = disp_dp_q;
    if (wrap_s && pending_q) begin
      disp_dig_d = shadow_dig_q;
      disp_dp_d  = shadow_dp_q;
      pending_d  = 1'b0;
    end else begin
      disp_dig_d = disp_dig_q;
      disp_dp_d  = disp_dp_q;
    end
    if (load) begin
      shadow_dig_d = digits_in;
      shadow_dp_d  = dp_in;
      pending_d    = 1'b1;
    end else begin
      shadow_dig_d = shadow_dig_q;
      shadow_dp_d  = shadow_dp_q;
    end
  end

  // Leading-zero mask: walk down from the top digit while nibbles are zero.
  // Digit 0 is never part of the mask.
  always_comb begin
    zero_run_s = 1'b1;
    lz_blank_s = {NUM_DIGITS{1'b0}};
    for (int i = NUM_DIGITS - 1; i >= 1; i--) begin
      zero_run_s    = zero_run_s & (disp_dig_q[i*4 +: 4] == 4'h0);
      lz_blank_s[i] = zero_run_s & LZ_ON;
    end
  end

  // Select the nibble, dp request and blank flag of the digit being scanned
  always_comb begin
    cur_nib_s = 4'h0;
    cur_dp_s  = 1'b0;
    cur_lz_s  = 1'b0;
    for (int i = 0; i < NUM_DIGITS; i++) begin
      cur_nib_s = cur_nib_s | (disp_dig_q[i*4 +: 4] & {4{idx_q == IDX_W'(i)}});
      cur_dp_s  = cur_dp_s  | (disp_dp_q[i]  & (idx_q == IDX_W'(i)));
      cur_lz_s  = cur_lz_s  | (lz_blank_s[i] & (idx_q == IDX_W'(i)));
    end
  end

  // Next output values; blanked leading digits still drive their dp
  always_comb begin
    seg_d = SEG_OFF;
    dp_d  = POL;
    an_d  = AN_OFF;
    if (blank_all) begin
      seg_d = SEG_OFF;
      dp_d  = POL;
      an_d  = AN_OFF;
    end else begin
      seg_d = (cur_lz_s ? 7'h00 : decode_glyph(cur_nib_s)) ^ SEG_OFF;
      dp_d  = cur_dp_s ^ POL;
      an_d  = (NUM_DIGITS'(1'b1) << idx_q) ^ AN_OFF;
    end
  end

  // State and output registers
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      cnt_q        <= {CNT_W{1'b0}};
      idx_q        <= {IDX_W{1'b0}};
      shadow_dig_q <= {(4*NUM_DIGITS){1'b0}};
      shadow_dp_q  <= {NUM_DIGITS{1'b0}};
      pending_q    <= 1'b0;
      disp_dig_q   <= {(4*NUM_DIGITS){1'b0}};
      disp_dp_q    <= {NUM_DIGITS{1'b0}};
      seg_q        <= SEG_OFF;
      dp_q         <= POL;
      an_q         <= AN_OFF;
      frame_done_q <= 1'b0;
    end else begin
      cnt_q        <= cnt_d;
      idx_q        <= idx_d;
      shadow_dig_q <= shadow_dig_d;
      shadow_dp_q  <= shadow_dp_d;
      pending_q    <= pending_d;
      disp_dig_q   <= disp_dig_d;
      disp_dp_q    <= disp_dp_d;
      seg_q        <= seg_d;
      dp_q         <= dp_d;
      an_q         <= an_d;
      frame_done_q <= frame_done_d;
    end
  end

  assign seg_out    = seg_q;
  assign dp_out     = dp_q;
  assign an_out     = an_q;
  assign frame_done = frame_done_q;

endmodule

// File: tb/tb_seg_scan_driver.sv
// -----------------------------------------------------------------------------
// tb_seg_scan_driver
//
// Two instances with SCAN_DIV=4, NUM_DIGITS=4 (16-cycle frames):
//   dut_a: HEX_MODE=1, BLANK_LEADING=1, ACTIVE_LOW=1
//   dut_b: HEX_MODE=0, BLANK_LEADING=0, ACTIVE_LOW=0
// The stimulus process pushes, one frame ahead, the hand-computed glyphs each
// frame must show. The monitor pops an entry at every frame start (and at
// reset release) and compares all outputs on cycles 1..15 of that frame.
// Glyph constants are written in active-low form; dut_b expects the inverse.
// -----------------------------------------------------------------------------
module tb_seg_scan_driver;

  localparam logic [6:0] S0 = 7'b1000000;
  localparam logic [6:0] S1 = 7'b1111001;
  localparam logic [6:0] S2 = 7'b0100100;
  localparam logic [6:0] S3 = 7'b0110000;
  localparam logic [6:0] S4 = 7'b0011001;
  localparam logic [6:0] S5 = 7'b0010010;
  localparam logic [6:0] SA = 7'b0001000;
  localparam logic [6:0] SF = 7'b0001110;
  localparam logic [6:0] SB = 7'b1111111;

  logic        clk       = 1'b0;
  logic        rst_n     = 1'b1;
  logic [15:0] digits_in = 16'h0000;
  logic [3:0]  dp_in     = 4'b0000;
  logic        load      = 1'b0;
  logic        blank_all = 1'b0;

  logic [6:0] seg_a, seg_b;
  logic       dp_a, dp_b;
  logic [3:0] an_a, an_b;
  logic       fd_a, fd_b;

  seg_scan_driver #(.NUM_DIGITS(4), .SCAN_DIV(4), .HEX_MODE(1),
                    .BLANK_LEADING(1), .ACTIVE_LOW(1)) dut_a (
    .clk(clk), .rst_n(rst_n), .digits_in(digits_in), .dp_in(dp_in),
    .load(load), .blank_all(blank_all), .seg_out(seg_a), .dp_out(dp_a),
    .an_out(an_a), .frame_done(fd_a));

  seg_scan_driver #(.NUM_DIGITS(4), .SCAN_DIV(4), .HEX_MODE(0),
                    .BLANK_LEADING(0), .ACTIVE_LOW(0)) dut_b (
    .clk(clk), .rst_n(rst_n), .digits_in(digits_in), .dp_in(dp_in),
    .load(load), .blank_all(blank_all), .seg_out(seg_b), .dp_out(dp_b),
    .an_out(an_b), .frame_done(fd_b));

  always #5 clk = ~clk;

  // ga/gb: glyphs {d3,d2,d1,d0} for dut_a/dut_b in active-low form
  // dp: active-low dp per digit; lo..hi: frame cycles forced dark by blank_all
  typedef struct {
    logic [27:0] ga;
    logic [27:0] gb;
    logic [3:0]  dp;
    int          lo;
    int          hi;
  } exp_t;

  exp_t        exp_q[$];
  logic [25:0] rst_q[$];
  int          n_pass  = 0;
  int          n_total = 0;

  function automatic exp_t mk(input logic [27:0] ga, input logic [27:0] gb,
                              input logic [3:0] dp, input int lo, input int hi);
    exp_t e;
    e.ga = ga; e.gb = gb; e.dp = dp; e.lo = lo; e.hi = hi;
    return e;
  endfunction

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] want);
    n_total++;
    if (act === want) n_pass++;
    else $display("FAIL %s: got %h, want %h", name, act, want);
  endtask

  // Reset checker: outputs must go inactive without any clock edge
  always @(negedge rst_n) begin : rst_chk
    logic [25:0] e;
    #1;
    if (rst_q.size() > 0) begin
      e = rst_q.pop_front();
      chk("reset_a", {19'd0, an_a, seg_a, dp_a, fd_a}, {19'd0, e[25:13]});
      chk("reset_b", {19'd0, an_b, seg_b, dp_b, fd_b}, {19'd0, e[12:0]});
    end else begin
      n_total++;
      $display("FAIL reset_unexpected: got reset, want none queued");
    end
  end

  // Monitor: frame alignment, frame length and per-cycle output comparison
  initial begin : monitor
    exp_t        cur;
    bit          have;
    int          j, gap, d, frame_no;
    logic        prev_rst;
    logic [12:0] ea, eb;
    have = 1'b0; j = 0; gap = 0; frame_no = 0; prev_rst = 1'b0;
    forever begin
      @(posedge clk); #1;
      if (!rst_n) begin
        have = 1'b0; gap = 0; prev_rst = 1'b0;
      end else begin
        gap++;
        if (fd_a || fd_b) begin
          chk($sformatf("frame_len f%0d", frame_no), gap, 16);
          chk($sformatf("fd_pair f%0d", frame_no), {30'd0, fd_a, fd_b}, 32'd3);
          gap = 0; frame_no++; have = 1'b0;
          if (exp_q.size() > 0) begin cur = exp_q.pop_front(); have = 1'b1; j = 0; end
        end else begin
          if (!prev_rst) begin
            have = 1'b0;
            if (exp_q.size() > 0) begin cur = exp_q.pop_front(); have = 1'b1; j = 0; end
          end
          if (have) begin
            j++;
            d = (j - 1) / 4;
            if (j >= cur.lo && j <= cur.hi) begin
              ea = {4'hF, 7'h7F, 1'b1, 1'b0};
              eb = 13'h0000;
            end else begin
              ea = {~(4'b0001 << d), cur.ga[d*7 +: 7], cur.dp[d], 1'b0};
              eb = {(4'b0001 << d), ~cur.gb[d*7 +: 7], ~cur.dp[d], 1'b0};
            end
            chk($sformatf("out_a f%0d j%0d", frame_no, j), {19'd0, an_a, seg_a, dp_a, fd_a}, {19'd0, ea});
            chk($sformatf("out_b f%0d j%0d", frame_no, j), {19'd0, an_b, seg_b, dp_b, fd_b}, {19'd0, eb});
            if (j >= 15) have = 1'b0;
          end
        end
        prev_rst = 1'b1;
      end
    end
  end

  task automatic wait_frame();
    int n;
    n = 0;
    do begin @(negedge clk); n++; end while (!fd_a && n < 100);
    if (!fd_a) begin
      n_total++;
      $display("FAIL wait_frame: got no frame_done in 100 cycles, want a pulse");
    end
  endtask

  task automatic do_load(input logic [15:0] d, input logic [3:0] p);
    digits_in = d; dp_in = p; load = 1'b1;
    @(negedge clk);
    load = 1'b0;
  endtask

  // Stimulus; comments give the frame number counted from reset release
  initial begin
    rst_q.push_back({4'hF, 7'h7F, 1'b1, 1'b0, 13'h0000});
    #3 rst_n = 1'b0;
    repeat (3) @(negedge clk);
    exp_q.push_back(mk({SB, SB, SB, S0}, {S0, S0, S0, S0}, 4'b1111, 99, 0));  // F0 idle
    rst_n = 1'b1;
    // F0: mid-frame hex load, shown from F1
    repeat (5) @(negedge clk);
    do_load(16'hA3F0, 4'b0010);
    exp_q.push_back(mk({SA, S3, SF, S0}, {SB, S3, SB, S0}, 4'b1101, 99, 0));  // F1
    wait_frame();
    // F1: leading zeros, dp on a blanked digit
    repeat (3) @(negedge clk);
    do_load(16'h0050, 4'b1000);
    exp_q.push_back(mk({SB, SB, S5, S0}, {S0, S0, S5, S0}, 4'b0111, 99, 0));  // F2
    wait_frame();
    // F2: all zeros -> only digit 0 lit
    repeat (3) @(negedge clk);
    do_load(16'h0000, 4'b0000);
    exp_q.push_back(mk({SB, SB, SB, S0}, {S0, S0, S0, S0}, 4'b1111, 99, 0));  // F3
    wait_frame();
    // F3: mid-frame load must not disturb F3
    repeat (7) @(negedge clk);
    do_load(16'h1234, 4'b0000);
    exp_q.push_back(mk({S1, S2, S3, S4}, {S1, S2, S3, S4}, 4'b1111, 99, 0));  // F4
    wait_frame();
    // F4: pending 0005, then 4321 lands exactly on the wrap edge
    repeat (3) @(negedge clk);
    do_load(16'h0005, 4'b0000);
    exp_q.push_back(mk({SB, SB, SB, S5}, {S0, S0, S0, S5}, 4'b1111, 99, 0));  // F5
    repeat (11) @(negedge clk);
    do_load(16'h4321, 4'b1000);
    exp_q.push_back(mk({S4, S3, S2, S1}, {S4, S3, S2, S1}, 4'b0111, 99, 0));  // F6
    wait_frame();
    // F6: announce a 5-cycle blank in F7
    exp_q.push_back(mk({S4, S3, S2, S1}, {S4, S3, S2, S1}, 4'b0111, 6, 10));  // F7
    wait_frame();
    // F7: blank_all sampled on edges 6..10
    exp_q.push_back(mk({S4, S3, S2, S1}, {S4, S3, S2, S1}, 4'b0111, 99, 0));  // F8
    repeat (5) @(negedge clk);
    blank_all = 1'b1;
    repeat (5) @(negedge clk);
    blank_all = 1'b0;
    wait_frame();
    wait_frame();
    // F9: pending load then asynchronous reset between edges
    do_load(16'h7777, 4'b1111);
    repeat (3) @(negedge clk);
    #2;
    rst_q.push_back({4'hF, 7'h7F, 1'b1, 1'b0, 13'h0000});
    rst_n = 1'b0;
    exp_q.push_back(mk({SB, SB, SB, S0}, {S0, S0, S0, S0}, 4'b1111, 99, 0));
    exp_q.push_back(mk({SB, SB, SB, S0}, {S0, S0, S0, S0}, 4'b1111, 99, 0));
    repeat (2) @(negedge clk);
    rst_n = 1'b1;
    wait_frame();
    wait_frame();
    repeat (2) @(negedge clk);
    chk("queue_drained", exp_q.size(), 0);
    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

  initial begin
    #100000;
    $display("FAIL watchdog: got timeout, want finish");
    $fatal(1, "watchdog");
  end

endmodule
